instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch unit for the multicycle ARM-subset core; the producer side of the instruction-field interface that the decode/control unit consumes.
- Owns the fetch PC and the instruction register. Issues word reads to instruction memory over a req/ack handshake and presents the latched instruction plus pre-sliced Op/Funct/Rd fields under a valid/ready handshake.
- Accepts PC redirects (branches, writes to R15) from the datapath.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned).

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- mem_req  out  1  read request to instruction memory.
- mem_addr  out  ADDR_W  word address of the request; bits [1:0] always 0.
- mem_rdata  in  32  read data, valid only when mem_ack=1.
- mem_ack  in  1  read completion; ignored unless mem_req=1.
- instr_valid  out  1  Instr and its fields are valid.
- instr_ready  in  1  decode accepts the instruction (handshake when valid & ready).
- Instr  out  32  instruction register.
- Op  out  2  Instr[27:26].
- Funct  out  6  Instr[25:20].
- Rd  out  4  Instr[15:12].
- InstrPC  out  ADDR_W  address of the held instruction.
- PCPlus8  out  ADDR_W  InstrPC+8 (R15 read value).
- pc_we  in  1  redirect strobe.
- pc_next  in  ADDR_W  redirect target; [1:0] forced to 0.

Behaviour:
- Reset (reset=0, async):
  - mem_req=0, instr_valid=0, Instr=0, InstrPC=RESET_PC, fetch PC=RESET_PC.
  - Prefetch buffer empty; state=IDLE.
- States:
  - IDLE: one cycle after reset release, unconditionally -> FETCH.
  - FETCH: mem_req=1, mem_addr=fetch PC held stable until mem_ack. Ack in the same cycle as req is legal (zero wait). On ack: Instr<=mem_rdata, InstrPC<=fetch PC -> VALID.
  - VALID: instr_valid=1; Instr, InstrPC and all fields held stable.
    - On handshake: fetch PC<=InstrPC+4 -> FETCH.
    - Result: minimum 2 cycles per instruction, no prefetch, zero-wait memory.
  - DRAIN: mem_req stays 1 at the stale address until mem_ack. Returned data discarded -> FETCH at the redirected PC.
- Redirect (pc_we=1), highest priority in every state; fetch PC<=pc_next & ~3.
  - IDLE or VALID without handshake: held instruction flushed (instr_valid=0 next cycle) -> FETCH.
  - VALID with handshake in the same cycle: instruction counts as accepted; next fetch is pc_next, not InstrPC+4.
  - FETCH, no ack this cycle: -> DRAIN.
  - FETCH, ack this cycle: data discarded -> FETCH at new PC.
  - DRAIN: target updated to the latest pc_next; stays in DRAIN.
- instr_valid never drops without a handshake or a redirect.
- Arithmetic: all PC additions are modulo 2^ADDR_W; wrap from all-ones to 0 is silent.
- Reset asserted mid-request: mem_req drops immediately (async). A later mem_ack is ignored because mem_req=0.

Optional Feature:
- PREFETCH_EN
- Defined: one-entry prefetch buffer.
  - While in VALID with the buffer empty and no redirect, issue a fetch of InstrPC+4.
  - On handshake with buffer full: Instr/InstrPC load from the buffer and instr_valid stays 1 (back-to-back, 1 instr/cycle).
  - On handshake with a prefetch still outstanding: -> FETCH, keep the request, no re-issue.
  - Redirect flushes the buffer. An outstanding prefetch goes through DRAIN.
- Undefined: no buffer; behaviour exactly as above.

Test Plan:
- Reset release, mem_ack tied 1, rdata=32'hE0821003 -> mem_req=1 @addr 0 one cycle after IDLE; instr_valid next cycle with Op=00, Funct=6'b001000, Rd=1, PCPlus8=8.
- Three wait states, instr_ready=1 -> mem_addr stable at 0 for 4 cycles; then accept; next mem_addr=4.
- instr_ready=0 for 5 cycles -> Instr, InstrPC and instr_valid=1 unchanged for all 5; no mem_req without PREFETCH_EN.
- pc_we with pc_next=32'h103 during outstanding FETCH (ack 2 cycles later) -> DRAIN, first data discarded; next mem_addr=32'h100; instr_valid stays 0 until the new data arrives.
- Handshake and pc_we (pc_next=32'h40) in the same VALID cycle -> next mem_addr=32'h40, not InstrPC+4; no duplicate instr_valid for the old instruction.
- reset=0 while mem_req=1 and before ack -> mem_req=0 immediately. After release, fetch restarts at RESET_PC and the late ack is ignored.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and decode.
// master = fetch unit side, slave = memory/decode/datapath side.
interface instr_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic              mem_ack;

  // Decode handshake: a transfer happens on every rising clk edge where
  // instr_valid & instr_ready are both 1; instr_valid never depends on instr_ready.
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       Instr;
  logic [1:0]        Op;
  logic [5:0]        Funct;
  logic [3:0]        Rd;
  logic [ADDR_W-1:0] InstrPC;
  logic [ADDR_W-1:0] PCPlus8;

  logic              pc_we;
  logic [ADDR_W-1:0] pc_next;

  modport master (
    output mem_req, mem_addr, instr_valid, Instr, Op, Funct, Rd, InstrPC, PCPlus8,
    input  mem_rdata, mem_ack, instr_ready, pc_we, pc_next
  );

  modport slave (
    input  mem_req, mem_addr, instr_valid, Instr, Op, Funct, Rd, InstrPC, PCPlus8,
    output mem_rdata, mem_ack, instr_ready, pc_we, pc_next
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetch PC, instruction register, memory req/ack and decode valid/ready.
// Optional one-entry prefetch buffer enabled by defining PREFETCH_EN.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  instr_fetch_if.master bus,
  output logic [1:0]    o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_drain_addr, w_drain_addr_nxt;
  logic [31:0]       r_instr, w_instr_nxt;
  logic [ADDR_W-1:0] r_instr_pc, w_instr_pc_nxt;

  logic              w_req;
  logic              w_ack;
  logic              w_hs;
  logic [ADDR_W-1:0] w_target;

`ifdef PREFETCH_EN
  logic              r_pf_full, w_pf_full_nxt;
  logic [31:0]       r_pf_data, w_pf_data_nxt;
  logic [ADDR_W-1:0] r_pf_addr, w_pf_addr_nxt;

  assign w_req = (r_state == S_FETCH) || (r_state == S_DRAIN) ||
                 ((r_state == S_VALID) && !r_pf_full);
`else
  assign w_req = (r_state == S_FETCH) || (r_state == S_DRAIN);
`endif

  assign w_ack    = w_req && bus.mem_ack;
  assign w_hs     = (r_state == S_VALID) && bus.instr_ready;
  assign w_target = bus.pc_next & ~ADDR_W'(3);

  // r_pc always holds the address of the next fetch; it advances by 4 when
  // data is captured, so acceptance of an instruction needs no extra adder.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_drain_addr_nxt = r_drain_addr;
    w_instr_nxt      = r_instr;
    w_instr_pc_nxt   = r_instr_pc;
`ifdef PREFETCH_EN
    w_pf_full_nxt    = r_pf_full;
    w_pf_data_nxt    = r_pf_data;
    w_pf_addr_nxt    = r_pf_addr;
`endif
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        if (bus.pc_we) w_pc_nxt = w_target;
      end
      S_FETCH: begin
        if (bus.pc_we) begin
          w_pc_nxt = w_target;
          if (!w_ack) begin
            w_state_nxt      = S_DRAIN;
            w_drain_addr_nxt = r_pc;
          end
        end else if (w_ack) begin
          w_instr_nxt    = bus.mem_rdata;
          w_instr_pc_nxt = r_pc;
          w_pc_nxt       = r_pc + ADDR_W'(4);
          w_state_nxt    = S_VALID;
        end
      end
      S_VALID: begin
`ifdef PREFETCH_EN
        if (bus.pc_we) begin
          w_pc_nxt      = w_target;
          w_pf_full_nxt = 1'b0;
          // An in-flight prefetch must complete at its old address first.
          if (!r_pf_full && !w_ack) begin
            w_state_nxt      = S_DRAIN;
            w_drain_addr_nxt = r_pc;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else if (w_hs) begin
          if (r_pf_full) begin
            w_instr_nxt    = r_pf_data;
            w_instr_pc_nxt = r_pf_addr;
            w_pf_full_nxt  = 1'b0;
          end else if (w_ack) begin
            w_instr_nxt    = bus.mem_rdata;
            w_instr_pc_nxt = r_pc;
            w_pc_nxt       = r_pc + ADDR_W'(4);
          end else begin
            w_state_nxt = S_FETCH;
          end
        end else if (w_ack) begin
          w_pf_full_nxt = 1'b1;
          w_pf_data_nxt = bus.mem_rdata;
          w_pf_addr_nxt = r_pc;
          w_pc_nxt      = r_pc + ADDR_W'(4);
        end
`else
        if (bus.pc_we) begin
          w_pc_nxt    = w_target;
          w_state_nxt = S_FETCH;
        end else if (w_hs) begin
          w_state_nxt = S_FETCH;
        end
`endif
      end
      S_DRAIN: begin
        if (bus.pc_we) w_pc_nxt = w_target;
        if (w_ack) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_drain_addr <= RESET_PC;
      r_instr      <= '0;
      r_instr_pc   <= RESET_PC;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_drain_addr <= w_drain_addr_nxt;
      r_instr      <= w_instr_nxt;
      r_instr_pc   <= w_instr_pc_nxt;
    end
  end

`ifdef PREFETCH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pf_full <= 1'b0;
      r_pf_data <= '0;
      r_pf_addr <= RESET_PC;
    end else begin
      r_pf_full <= w_pf_full_nxt;
      r_pf_data <= w_pf_data_nxt;
      r_pf_addr <= w_pf_addr_nxt;
    end
  end
`endif

  assign bus.mem_req     = w_req;
  assign bus.mem_addr    = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign bus.instr_valid = (r_state == S_VALID);
  assign bus.Instr       = r_instr;
  assign bus.Op          = r_instr[27:26];
  assign bus.Funct       = r_instr[25:20];
  assign bus.Rd          = r_instr[15:12];
  assign bus.InstrPC     = r_instr_pc;
  assign bus.PCPlus8     = r_instr_pc + ADDR_W'(8);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, then random memory latency, ready and
// redirects checked against a transaction-level model of the accepted instruction stream.
module tb_instr_fetch;
  localparam int AW = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         checks   = 0;
  int         failures = 0;

  instr_fetch_if #(.ADDR_W(AW)) bus ();

  instr_fetch #(.ADDR_W(AW), .RESET_PC('0)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory image: every word address holds a distinct value.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
  endfunction

  // ---------------- scoreboard / model state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc, w_exp, tgt, addr, prev_addr, prev_instr, prev_ipc;
  logic        v, req, ack_eff, we, hs;
  logic        prev_req, prev_ack, prev_v, prev_hs, prev_we;
  int          wait_left, since_hs, hs_count;

  initial begin
    reset           = 1'b0;
    bus.mem_ack     = 1'b1;
    bus.mem_rdata   = 32'hE082_1003;
    bus.instr_ready = 1'b0;
    bus.pc_we       = 1'b0;
    bus.pc_next     = '0;
    repeat (3) tick();

    // Reset state
    check("rst_req",    32'(bus.mem_req), 32'd0);
    check("rst_valid",  32'(bus.instr_valid), 32'd0);
    check("rst_instr",  bus.Instr, 32'd0);
    check("rst_ipc",    bus.InstrPC, 32'd0);
    check("rst_pc8",    bus.PCPlus8, 32'd8);

    // Zero-wait first fetch
    reset = 1'b1;
    check("idle_req", 32'(bus.mem_req), 32'd0);
    tick();
    check("f0_req",  32'(bus.mem_req), 32'd1);
    check("f0_addr", bus.mem_addr, 32'd0);
    tick();
    check("v0_valid", 32'(bus.instr_valid), 32'd1);
    check("v0_instr", bus.Instr, 32'hE082_1003);
    check("v0_op",    32'(bus.Op), 32'd0);
    check("v0_funct", 32'(bus.Funct), 32'b001000);
    check("v0_rd",    32'(bus.Rd), 32'd1);
    check("v0_pc8",   bus.PCPlus8, 32'd8);
    bus.mem_ack = 1'b0;

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 32'(bus.instr_valid), 32'd1);
      check("stall_instr", bus.Instr, 32'hE082_1003);
      check("stall_ipc",   bus.InstrPC, 32'd0);
      check("stall_req",   32'(bus.mem_req), 32'd0);
    end

    // Accept, then a fetch with three wait states
    bus.instr_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("ws_req",  32'(bus.mem_req), 32'd1);
      check("ws_addr", bus.mem_addr, 32'd4);
      check("ws_valid", 32'(bus.instr_valid), 32'd0);
      if (i == 3) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hE280_0001;
      end
      tick();
    end
    bus.mem_ack = 1'b0;
    check("ws_v_ipc",   bus.InstrPC, 32'd4);
    check("ws_v_instr", bus.Instr, 32'hE280_0001);
    tick();
    check("next_addr", bus.mem_addr, 32'd8);
    check("next_req",  32'(bus.mem_req), 32'd1);

    // Redirect while a fetch is outstanding
    bus.pc_we   = 1'b1;
    bus.pc_next = 32'h103;
    tick();
    bus.pc_we = 1'b0;
    check("drain_req",   32'(bus.mem_req), 32'd1);
    check("drain_addr",  bus.mem_addr, 32'd8);
    check("drain_valid", 32'(bus.instr_valid), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    tick();
    bus.mem_rdata = 32'hE1A0_F00E;
    check("redir_addr",  bus.mem_addr, 32'h100);
    check("redir_valid", 32'(bus.instr_valid), 32'd0);
    tick();
    bus.mem_ack = 1'b0;
    check("redir_ipc",   bus.InstrPC, 32'h100);
    check("redir_instr", bus.Instr, 32'hE1A0_F00E);

    // Handshake and redirect in the same cycle
    bus.pc_we   = 1'b1;
    bus.pc_next = 32'h40;
    tick();
    bus.pc_we = 1'b0;
    check("hsr_valid", 32'(bus.instr_valid), 32'd0);
    check("hsr_addr",  bus.mem_addr, 32'h40);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hE3A0_1005;
    tick();
    bus.mem_ack = 1'b0;
    check("hsr_ipc", bus.InstrPC, 32'h40);
    tick();
    check("hsr_next", bus.mem_addr, 32'h44);

    // Asynchronous reset in the middle of a request
    bus.instr_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_req",   32'(bus.mem_req), 32'd0);
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_ipc",   bus.InstrPC, 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0_BAD0;
    tick();
    reset = 1'b1;
    check("arst_idle_req", 32'(bus.mem_req), 32'd0);
    tick();
    bus.mem_rdata = 32'hE082_1003;
    check("arst_f_addr", bus.mem_addr, 32'd0);
    check("arst_f_req",  32'(bus.mem_req), 32'd1);
    tick();
    bus.mem_ack = 1'b0;
    check("arst_v_instr", bus.Instr, 32'hE082_1003);
    check("arst_v_ipc",   bus.InstrPC, 32'd0);

    // Random phase against the accepted-stream model
    reset = 1'b0;
    tick();
    tick();
    reset     = 1'b1;
    exp_pc    = '0;
    prev_req  = 1'b0; prev_ack = 1'b0; prev_v = 1'b0; prev_hs = 1'b0; prev_we = 1'b0;
    prev_addr = '0;   prev_instr = '0; prev_ipc = '0;
    wait_left = 0;    since_hs = 0;    hs_count = 0;
    for (int cyc = 0; cyc < 1200; cyc++) begin
      v    = bus.instr_valid;
      req  = bus.mem_req;
      addr = bus.mem_addr;
      if (prev_req && !prev_ack) begin
        check("req_hold",  32'(req), 32'd1);
        check("addr_hold", addr, prev_addr);
      end
      if (prev_v && !prev_hs && !prev_we) begin
        check("valid_hold", 32'(v), 32'd1);
        check("instr_hold", bus.Instr, prev_instr);
        check("ipc_hold",   bus.InstrPC, prev_ipc);
      end
      if (prev_we) check("flush", 32'(v), 32'd0);
      if (v)       check("no_prefetch", 32'(req), 32'd0);
      if (req)     check("addr_align", 32'(addr[1:0]), 32'd0);

      if (req && !(prev_req && !prev_ack)) wait_left = $urandom_range(0, 3);
      if (req) begin
        ack_eff = (wait_left == 0);
        if (wait_left > 0) wait_left--;
        bus.mem_ack = ack_eff;
      end else begin
        ack_eff     = 1'b0;
        bus.mem_ack = ($urandom_range(0, 3) == 0);
      end
      bus.mem_rdata   = ack_eff ? mem_fn(addr) : $urandom;
      bus.instr_ready = 1'($urandom_range(0, 1));
      we              = ($urandom_range(0, 9) == 0);
      bus.pc_we       = we;
      bus.pc_next     = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom_range(0, 255));
      tgt = {bus.pc_next[31:2], 2'b00};
      hs  = v && bus.instr_ready;

      if (hs) begin
        exp_q.push_back(exp_pc);
        w_exp = mem_fn(exp_q[0]);
        check("hs_ipc",   bus.InstrPC, exp_q[0]);
        check("hs_instr", bus.Instr, w_exp);
        check("hs_op",    32'(bus.Op), 32'(w_exp[27:26]));
        check("hs_funct", 32'(bus.Funct), 32'(w_exp[25:20]));
        check("hs_rd",    32'(bus.Rd), 32'(w_exp[15:12]));
        check("hs_pc8",   bus.PCPlus8, exp_q[0] + 32'd8);
        void'(exp_q.pop_front());
        hs_count++;
        since_hs = 0;
        exp_pc   = we ? tgt : exp_pc + 32'd4;
      end else begin
        if (we) exp_pc = tgt;
        since_hs++;
      end

      if (since_hs > 80) begin
        check("progress_timeout", 32'(since_hs), 32'd0);
        break;
      end

      prev_req   = req;
      prev_ack   = ack_eff;
      prev_addr  = addr;
      prev_v     = v;
      prev_hs    = hs;
      prev_we    = we;
      prev_instr = bus.Instr;
      prev_ipc   = bus.InstrPC;
      tick();
      bus.pc_we = 1'b0;
    end
    check("hs_count_min", 32'(hs_count >= 60), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
